seq_gen_tx: RTL and testbench

Serial pattern transmitter: loads a PAT_W-bit pattern and a repetition count on a start pulse, then emits the pattern MSB-first, one bit per clock, for the requested number of repetitions. This block is the stimulus and transmit side of the serial bit-stream interface consumed by the team's sequence detectors. Its `x` output connects directly to a detector's `x` input. Status flags `busy`, `bit_valid` and `done` let a controller or bench sequence multiple transmissions.

---
 rtl/seq_gen_tx_if.sv | 24 ++
 rtl/seq_gen_tx.sv | 113 +++++++++++
 tb/tb_seq_gen_tx.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/seq_gen_tx_if.sv
// Serial pattern transmitter bus: start/pattern/reps request side plus the
// serial bit-stream and status flags returned by seq_gen_tx.
interface seq_gen_tx_if #(
  parameter int PAT_W = 4,
  parameter int REP_W = 8
);
  logic             start;
  logic [PAT_W-1:0] pattern;
  logic [REP_W-1:0] reps;
  logic             x;
  logic             bit_valid;
  logic             busy;
  logic             done;

  modport master (
    output start, pattern, reps,
    input  x, bit_valid, busy, done
  );

  modport slave (
    input  start, pattern, reps,
    output x, bit_valid, busy, done
  );
endinterface

// File: rtl/seq_gen_tx.sv
// Serial pattern transmitter: sends a captured pattern MSB-first for a given
// number of repetitions. Define SEQ_GEN_TX_GAP_EN to insert one idle bit between repetitions.
module seq_gen_tx #(
  parameter int PAT_W = 4,
  parameter int REP_W = 8
) (
  input  logic         clk,
  input  logic         rst,
  seq_gen_tx_if.slave  bus
);

  localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAT_W - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [REP_W-1:0] REP_ONE  = REP_W'(1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
`ifdef SEQ_GEN_TX_GAP_EN
  localparam logic [1:0] GAP   = 2'd2;
`endif
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]       state;
  logic [PAT_W-1:0] pat_q;
  logic [IDX_W-1:0] idx;
  logic [REP_W-1:0] rep_left;
  logic             x_q;
  logic             valid_q;
  logic             busy_q;
  logic             done_q;

  assign bus.x         = x_q;
  assign bus.bit_valid = valid_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

  // Outputs are registered from the next-state decision, so x already shows
  // the bit belonging to the state being entered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      pat_q    <= '0;
      idx      <= '0;
      rep_left <= '0;
      x_q      <= 1'b0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (bus.reps != '0) begin
              state    <= SHIFT;
              pat_q    <= bus.pattern;
              idx      <= IDX_LAST;
              rep_left <= bus.reps - REP_ONE;
              x_q      <= bus.pattern[PAT_W-1];
              valid_q  <= 1'b1;
              busy_q   <= 1'b1;
            end else begin
              state  <= DONE;
              done_q <= 1'b1;
            end
          end
        end

        SHIFT: begin
          if (idx != '0) begin
            idx <= idx - IDX_ONE;
            x_q <= pat_q[idx - IDX_ONE];
          end else if (rep_left != '0) begin
            // rep_left counts repetitions still to go after the current one
            rep_left <= rep_left - REP_ONE;
            idx      <= IDX_LAST;
`ifdef SEQ_GEN_TX_GAP_EN
            state    <= GAP;
            x_q      <= 1'b0;
            valid_q  <= 1'b0;
`else
            x_q      <= pat_q[PAT_W-1];
`endif
          end else begin
            state   <= DONE;
            x_q     <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end

`ifdef SEQ_GEN_TX_GAP_EN
        GAP: begin
          state   <= SHIFT;
          x_q     <= pat_q[PAT_W-1];
          valid_q <= 1'b1;
        end
`endif

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_gen_tx.sv
// Directed bench for seq_gen_tx; expectations follow SEQ_GEN_TX_GAP_EN so the
// same file covers both builds.
module tb_seq_gen_tx;
  localparam int PAT_W = 4;
  localparam int REP_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int compared = 0;
  int mismatched = 0;

  seq_gen_tx_if #(.PAT_W(PAT_W), .REP_W(REP_W)) bus ();

  seq_gen_tx #(.PAT_W(PAT_W), .REP_W(REP_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Status packed as {x, bit_valid, busy, done}
  function automatic logic [3:0] status();
    return {bus.x, bus.bit_valid, bus.busy, bus.done};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] pat, input logic [7:0] r);
    bus.start   = 1'b1;
    bus.pattern = pat;
    bus.reps    = r;
    tick();
    bus.start   = 1'b0;
  endtask

  // A 1010 overlapping detector is modelled on x to confirm boundary overlap
  task automatic sendAndCheck(input string tag, input logic [3:0] pat, input logic [7:0] r,
                              input logic [31:0] expX, input logic [31:0] expV,
                              input int len, input int expHits);
    logic [3:0] hist;
    int hits;
    hist = 4'b0000;
    hits = 0;
    applyStimulus(pat, r);
    for (int i = 0; i < len; i++) begin
      checkOutput($sformatf("%s bit%0d", tag, i), status(),
                  {expX[len-1-i], expV[len-1-i], 1'b1, 1'b0});
      hist = {hist[2:0], bus.x};
      if (hist == 4'b1010) hits++;
      tick();
    end
    checkOutput({tag, " done"}, status(), 4'b0001);
    checkOutput({tag, " hits"}, hits, expHits);
    tick();
    checkOutput({tag, " idle"}, status(), 4'b0000);
  endtask

  initial begin
    bus.start   = 1'b1;
    bus.pattern = 4'b1111;
    bus.reps    = 8'd1;
    rst         = 1'b0;

    repeat (2) begin
      tick();
      checkOutput("reset hold", status(), 4'b0000);
    end
    #2;
    rst       = 1'b1;
    bus.start = 1'b0;
    repeat (2) begin
      tick();
      checkOutput("idle after reset", status(), 4'b0000);
    end

    sendAndCheck("basic", 4'b1010, 8'd1, 32'b1010, 32'b1111, 4, 1);

`ifdef SEQ_GEN_TX_GAP_EN
    sendAndCheck("gap", 4'b1010, 8'd3, 32'b10100101001010, 32'b11110111101111, 14, 3);
`else
    sendAndCheck("b2b", 4'b1010, 8'd3, 32'b101010101010, 32'b111111111111, 12, 5);
`endif

    applyStimulus(4'b1010, 8'd0);
    checkOutput("reps0 done", status(), 4'b0001);
    tick();
    checkOutput("reps0 idle", status(), 4'b0000);

    // start pulsed mid-transmission must not disturb the running pattern
    applyStimulus(4'b1010, 8'd1);
    checkOutput("ignore bit0", status(), 4'b1110);
    bus.start   = 1'b1;
    bus.pattern = 4'b1111;
    bus.reps    = 8'd5;
    tick();
    bus.start   = 1'b0;
    checkOutput("ignore bit1", status(), 4'b0110);
    tick();
    checkOutput("ignore bit2", status(), 4'b1110);
    tick();
    checkOutput("ignore bit3", status(), 4'b0110);
    tick();
    checkOutput("ignore done", status(), 4'b0001);
    tick();
    checkOutput("ignore idle", status(), 4'b0000);
    tick();
    checkOutput("ignore no rerun", status(), 4'b0000);

    applyStimulus(4'b1010, 8'd3);
    repeat (5) tick();
`ifdef SEQ_GEN_TX_GAP_EN
    checkOutput("abort pre", status(), 4'b1110);
`else
    checkOutput("abort pre", status(), 4'b0110);
`endif
    #2;
    rst = 1'b0;
    #1;
    checkOutput("abort async", status(), 4'b0000);
    repeat (3) begin
      tick();
      checkOutput("abort hold", status(), 4'b0000);
    end
    #2;
    rst = 1'b1;
    tick();
    checkOutput("abort released", status(), 4'b0000);

    sendAndCheck("after abort", 4'b0110, 8'd1, 32'b0110, 32'b1111, 4, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
